// File: rtl/spi_pkg.sv
// Shared types and helpers for the byte-oriented SPI master.
package spi_pkg;

    localparam int SPI_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_LOW    = 3'd2,
        ST_HIGH   = 3'd3,
        ST_GAP    = 3'd4,
        ST_HOLD   = 3'd5,
        ST_CSIDLE = 3'd6
    } spi_master_state_t;

    // Phase timer width. SETUP loads CS_SETUP+1 (one extra cycle for the
    // latch-then-drive-CS step), so the counter must hold max+1.
    function automatic int phase_timer_width(input int half_div, input int cs_setup,
                                             input int cs_hold, input int cs_idle,
                                             input int byte_gap);
        int m;
        m = half_div;
        if (cs_setup > m) m = cs_setup;
        if (cs_hold  > m) m = cs_hold;
        if (cs_idle  > m) m = cs_idle;
        if (byte_gap > m) m = byte_gap;
        return $clog2(m + 2);
    endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter; expired pulses for one cycle when a loaded
// interval of load_val cycles has elapsed.
module spi_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);
    logic [W-1:0] cnt;
    logic         armed;

    // Count down after a load; disarm once zero is reached so expired is a single pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (load) begin
            cnt   <= load_val - W'(1);
            armed <= 1'b1;
        end else if (armed) begin
            if (cnt == '0) armed <= 1'b0;
            else           cnt   <= cnt - W'(1);
        end
    end

    assign expired = armed && (cnt == '0);

endmodule

// File: rtl/spi_master_byte.sv
// SPI mode-0 master, one byte per request, CS held across bytes until a
// byte flagged last completes. All outputs are registered.
module spi_master_byte
    import spi_pkg::*;
#(
    parameter int HALF_DIV = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 4,
    parameter int BYTE_GAP = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx,
    input  logic       last,
    output logic       ready,
    output logic       busy,
    output logic [7:0] rx,
    output logic       rx_valid,
    output logic       spi_cs_n,
    output logic       spi_sclk,
    output logic       spi_tx,
    input  logic       spi_rx
);
    localparam int TW = phase_timer_width(HALF_DIV, CS_SETUP, CS_HOLD, CS_IDLE, BYTE_GAP);
    localparam logic [TW-1:0] T_SETUP = TW'(CS_SETUP + 1);
    localparam logic [TW-1:0] T_HALF  = TW'(HALF_DIV);
    localparam logic [TW-1:0] T_HOLD  = TW'(CS_HOLD);
    localparam logic [TW-1:0] T_IDLE  = TW'(CS_IDLE);
    localparam logic [TW-1:0] T_GAP   = TW'(BYTE_GAP);

    if (HALF_DIV < 1 || CS_SETUP < 1 || CS_HOLD < 1 || CS_IDLE < 1 || BYTE_GAP < 1) begin : g_param_check
        $error("spi_master_byte: all timing parameters must be >= 1");
    end

    spi_master_state_t state, state_d;

    logic [SPI_BITS-1:0] tx_shift, tx_shift_d;
    logic [SPI_BITS-1:0] rx_shift, rx_shift_d;
    logic [2:0]          bit_cnt, bit_cnt_d;
    logic                last_q, last_d;

    logic       ready_d, busy_d, rx_valid_d, cs_n_d, sclk_d, spi_tx_d;
    logic [7:0] rx_d;

    logic          tmr_load, tmr_expired;
    logic [TW-1:0] tmr_val;

    logic accept;
    assign accept = start && ready;

    spi_phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_d;
    end

    // Next-state: every timed state advances on the phase-timer pulse.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:   if (accept)      state_d = ST_SETUP;
            ST_SETUP:  if (tmr_expired) state_d = ST_LOW;
            ST_LOW:    if (tmr_expired) state_d = ST_HIGH;
            ST_HIGH:   if (tmr_expired) begin
                           if (bit_cnt != 3'd0) state_d = ST_LOW;
                           else if (last_q)     state_d = ST_HOLD;
                           else                 state_d = ST_GAP;
                       end
            ST_GAP:    if (accept)      state_d = ST_LOW;
            ST_HOLD:   if (tmr_expired) state_d = ST_CSIDLE;
            ST_CSIDLE: if (tmr_expired) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values and timer reloads for each state.
    always_comb begin
        tx_shift_d = tx_shift;
        rx_shift_d = rx_shift;
        bit_cnt_d  = bit_cnt;
        last_d     = last_q;
        ready_d    = ready;
        busy_d     = busy;
        rx_d       = rx;
        rx_valid_d = 1'b0;
        cs_n_d     = spi_cs_n;
        sclk_d     = spi_sclk;
        spi_tx_d   = spi_tx;
        tmr_load   = 1'b0;
        tmr_val    = T_HALF;
        case (state)
            ST_IDLE: if (accept) begin
                tx_shift_d = tx;
                last_d     = last;
                bit_cnt_d  = 3'(SPI_BITS - 1);
                ready_d    = 1'b0;
                busy_d     = 1'b1;
                tmr_load   = 1'b1;
                tmr_val    = T_SETUP;
            end
            ST_SETUP: begin
                // CS and the first data bit go out one edge after the latch.
                cs_n_d   = 1'b0;
                spi_tx_d = tx_shift[SPI_BITS-1];
                if (tmr_expired) tmr_load = 1'b1;
            end
            ST_LOW: if (tmr_expired) begin
                sclk_d     = 1'b1;
                rx_shift_d = {rx_shift[SPI_BITS-2:0], spi_rx};
                tmr_load   = 1'b1;
            end
            ST_HIGH: if (tmr_expired) begin
                sclk_d   = 1'b0;
                tmr_load = 1'b1;
                if (bit_cnt != 3'd0) begin
                    bit_cnt_d  = bit_cnt - 3'd1;
                    tx_shift_d = {tx_shift[SPI_BITS-2:0], 1'b0};
                    spi_tx_d   = tx_shift[SPI_BITS-2];
                end else begin
                    rx_d       = rx_shift;
                    rx_valid_d = 1'b1;
                    tmr_val    = last_q ? T_HOLD : T_GAP;
                end
            end
            ST_GAP: begin
                if (tmr_expired) ready_d = 1'b1;
                if (accept) begin
                    tx_shift_d = tx;
                    last_d     = last;
                    bit_cnt_d  = 3'(SPI_BITS - 1);
                    ready_d    = 1'b0;
                    spi_tx_d   = tx[7];
                    tmr_load   = 1'b1;
                end
            end
            ST_HOLD: if (tmr_expired) begin
                cs_n_d   = 1'b1;
                spi_tx_d = 1'b0;
                tmr_load = 1'b1;
                tmr_val  = T_IDLE;
            end
            ST_CSIDLE: if (tmr_expired) begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            last_q   <= 1'b0;
            ready    <= 1'b1;
            busy     <= 1'b0;
            rx       <= '0;
            rx_valid <= 1'b0;
            spi_cs_n <= 1'b1;
            spi_sclk <= 1'b0;
            spi_tx   <= 1'b0;
        end else begin
            tx_shift <= tx_shift_d;
            rx_shift <= rx_shift_d;
            bit_cnt  <= bit_cnt_d;
            last_q   <= last_d;
            ready    <= ready_d;
            busy     <= busy_d;
            rx       <= rx_d;
            rx_valid <= rx_valid_d;
            spi_cs_n <= cs_n_d;
            spi_sclk <= sclk_d;
            spi_tx   <= spi_tx_d;
        end
    end

endmodule

// File: tb/tb_spi_master_byte.sv
// Bench for spi_master_byte: per-cycle timeline model painted on each accept,
// an SPI responder peer, and a HALF_DIV=1 instance for the fast-clock case.
module tb_spi_master_byte;
    localparam int H = 2, CSS = 2, CSH = 2, CSI = 4, BG = 4;
    localparam int MAXC = 2048;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, last;
    logic [7:0] tx;
    logic       ready, busy, rx_valid, spi_cs_n, spi_sclk, spi_tx, spi_rx;
    logic [7:0] rx;

    logic       f_start, f_last;
    logic [7:0] f_tx, f_rx;
    logic       f_ready, f_busy, f_rx_valid, f_cs_n, f_sclk, f_spi_tx;

    logic [1:0] mode;   // 0 loopback, 1 tied 0, 2 tied 1, 3 responder
    logic       resp_miso = 1'b0;

    int cyc = 0, n_assert = 0, n_fail = 0, n_rise = 0, f_rise = 0, f_hi = 0, fidx = 0;
    bit chk_en = 1'b0;

    // Expected value of each output after edge e.
    logic       e_cs[MAXC], e_sclk[MAXC], e_tx[MAXC], e_rxv[MAXC], e_busy[MAXC], e_ready[MAXC];
    logic [7:0] e_rx[MAXC];

    logic [7:0] reply [2] = '{8'h5A, 8'hC3};
    logic [7:0] resp_got[$], m_rx[$];
    logic [7:0] r_cur = 8'h00, r_sr = 8'h00, f_bits = 8'h00;
    int         r_cnt = 0, r_idx = 0;

    assign spi_rx = (mode == 2'd0) ? spi_tx : (mode == 2'd1) ? 1'b0 :
                    (mode == 2'd2) ? 1'b1 : resp_miso;

    spi_master_byte dut (
        .clk(clk), .reset(reset), .start(start), .tx(tx), .last(last),
        .ready(ready), .busy(busy), .rx(rx), .rx_valid(rx_valid),
        .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_tx(spi_tx), .spi_rx(spi_rx)
    );

    spi_master_byte #(.HALF_DIV(1)) dut_fast (
        .clk(clk), .reset(reset), .start(f_start), .tx(f_tx), .last(f_last),
        .ready(f_ready), .busy(f_busy), .rx(f_rx), .rx_valid(f_rx_valid),
        .spi_cs_n(f_cs_n), .spi_sclk(f_sclk), .spi_tx(f_spi_tx), .spi_rx(f_spi_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder peer (mode 0): samples MOSI on rise, shifts MISO on fall.
    always @(negedge spi_cs_n) begin
        r_cnt = 0; r_idx = 0; r_cur = reply[0]; resp_miso = r_cur[7];
    end
    always @(posedge spi_sclk) begin
        n_rise++;
        r_sr = {r_sr[6:0], spi_tx};
        r_cnt++;
        if (r_cnt == 8) begin
            resp_got.push_back(r_sr);
            r_cnt = 0; r_idx++;
            r_cur = (r_idx < 2) ? reply[r_idx] : 8'h00;
        end
    end
    always @(negedge spi_sclk) resp_miso = r_cur[7 - r_cnt];

    always @(posedge f_sclk) begin
        f_rise++;
        f_bits = {f_bits[6:0], f_spi_tx};
    end
    always @(negedge clk) begin
        if (!f_cs_n && f_spi_tx) f_hi++;
        if (rx_valid === 1'b1) m_rx.push_back(rx);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, got, exp);
        end
    endtask

    // Per-cycle comparison against the painted timeline.
    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            chk("spi_cs_n", 32'(spi_cs_n), 32'(e_cs[cyc]));
            chk("spi_sclk", 32'(spi_sclk), 32'(e_sclk[cyc]));
            chk("spi_tx",   32'(spi_tx),   32'(e_tx[cyc]));
            chk("rx_valid", 32'(rx_valid), 32'(e_rxv[cyc]));
            chk("busy",     32'(busy),     32'(e_busy[cyc]));
            chk("ready",    32'(ready),    32'(e_ready[cyc]));
            if (e_rxv[cyc]) chk("rx", 32'(rx), 32'(e_rx[cyc]));
        end
    end

    task automatic paint_idle(input int e0);
        for (int e = e0; e < MAXC; e++) begin
            e_cs[e] = 1'b1; e_sclk[e] = 1'b0; e_tx[e] = 1'b0;
            e_rxv[e] = 1'b0; e_busy[e] = 1'b0; e_ready[e] = 1'b1; e_rx[e] = 8'h00;
        end
    endtask

    // Timeline of one byte accepted at edge a, assuming nothing else is accepted.
    task automatic paint_accept(input int a, input logic from_idle, input logic [7:0] t,
                                input logic l, input logic [7:0] rxb);
        int s, b0, c, cs_up, rdy_at, i;
        s      = from_idle ? a + 1 + CSS : a;   // first LOW phase starts here
        b0     = from_idle ? a + 1 : a;         // first data bit driven
        c      = s + 16 * H;                     // last falling edge, rx_valid
        cs_up  = c + CSH;
        rdy_at = l ? cs_up + CSI : c + BG;
        for (int e = a; e < MAXC; e++) begin
            e_ready[e] = (e >= rdy_at);
            e_busy[e]  = !l || (e < cs_up + CSI);
            e_cs[e]    = (e < b0) || (l && e >= cs_up);
            e_sclk[e]  = (e >= s) && (e < c) && (((e - s) / H) % 2 == 1);
            e_rxv[e]   = (e == c);
            e_rx[e]    = rxb;
            if (e < b0 || (l && e >= cs_up)) e_tx[e] = 1'b0;
            else begin
                i = (e < s) ? 0 : (e - s) / (2 * H);
                if (i > 7) i = 7;
                e_tx[e] = t[7 - i];
            end
        end
    endtask

    // Drive one cycle of stimulus (at a negedge); update the model if accepted.
    task automatic cycle(input logic s, input logic [7:0] t, input logic l);
        logic fi;
        logic [7:0] rxb;
        start = s; tx = t; last = l;
        if (s && e_ready[cyc]) begin
            fi = e_cs[cyc];
            if (fi) fidx = 0; else fidx++;
            case (mode)
                2'd0:    rxb = t;
                2'd1:    rxb = 8'h00;
                2'd2:    rxb = 8'hFF;
                default: rxb = (fidx < 2) ? reply[fidx] : 8'h00;
            endcase
            paint_accept(cyc + 1, fi, t, l, rxb);
        end
        @(negedge clk);
    endtask

    task automatic step();
        cycle(1'b0, 8'($urandom), 1'($urandom));
    endtask

    // Wait (bounded) for: 0 rx_valid, 1 cs_n high, 2 ready, 3 sclk high, 4 fast rx_valid, 5 fast cs_n high.
    task automatic wait_sig(input int which, input int lim, output int t);
        logic hit;
        t = -1;
        for (int k = 0; k < lim; k++) begin
            case (which)
                0: hit = rx_valid;
                1: hit = spi_cs_n;
                2: hit = ready;
                3: hit = spi_sclk;
                4: hit = f_rx_valid;
                default: hit = f_cs_n;
            endcase
            if (hit === 1'b1) begin t = cyc; return; end
            step();
        end
        chk($sformatf("timeout_%0d", which), 32'd0, 32'd1);
    endtask

    // Close any open frame and wait until the model is back in IDLE.
    task automatic drain();
        for (int k = 0; k < 500; k++) begin
            if (e_cs[cyc] && !e_busy[cyc] && e_ready[cyc]) return;
            if (e_ready[cyc]) cycle(1'b1, 8'($urandom), 1'b1);
            else              step();
        end
        chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int a0, tv, tcs, tr, r0, ts, tv1;
        reset = 1'b1; start = 1'b0; tx = 8'h00; last = 1'b0; mode = 2'd0;
        f_start = 1'b0; f_tx = 8'h00; f_last = 1'b0;
        paint_idle(0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("rst_sclk", 32'(spi_sclk), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rx", 32'(rx), 32'h00);
        chk_en = 1'b1;
        @(negedge clk);

        // Loopback 0xA5, single byte.
        a0 = cyc + 1; r0 = n_rise;
        cycle(1'b1, 8'hA5, 1'b1);
        wait_sig(0, 100, tv);
        chk("a5_latency", 32'(tv - a0), 32'd35);
        chk("a5_rx", 32'(rx), 32'hA5);
        wait_sig(1, 20, tcs);
        chk("a5_cs_rise", 32'(tcs - tv), 32'd2);
        wait_sig(2, 20, tr);
        chk("a5_ready", 32'(tr - tcs), 32'd4);
        chk("a5_rises", 32'(n_rise - r0), 32'd8);
        drain();

        // Two-byte frame against the responder.
        mode = 2'd3; m_rx.delete(); resp_got.delete();
        cycle(1'b1, 8'h3C, 1'b0);
        wait_sig(0, 100, tv1);
        for (int k = 0; k < 20 && !e_ready[cyc]; k++) step();
        cycle(1'b1, 8'h81, 1'b1);
        wait_sig(3, 20, ts);
        chk("gap_cycles", 32'(ts - tv1), 32'd7);
        chk("gap_cs_low", 32'(spi_cs_n), 32'd0);
        wait_sig(0, 100, tv);
        drain();
        chk("resp_n", 32'(resp_got.size()), 32'd2);
        chk("resp_b0", 32'(resp_got[0]), 32'h3C);
        chk("resp_b1", 32'(resp_got[1]), 32'h81);
        chk("mrx_n", 32'(m_rx.size()), 32'd2);
        chk("mrx_b0", 32'(m_rx[0]), 32'h5A);
        chk("mrx_b1", 32'(m_rx[1]), 32'hC3);

        // MISO tied high, then low.
        mode = 2'd2;
        cycle(1'b1, 8'h00, 1'b1);
        wait_sig(0, 100, tv);
        chk("tied1_rx", 32'(rx), 32'hFF);
        drain();
        mode = 2'd1;
        cycle(1'b1, 8'hFF, 1'b1);
        wait_sig(0, 100, tv);
        chk("tied0_rx", 32'(rx), 32'h00);
        drain();

        // Random traffic in loopback; start often lands while busy.
        mode = 2'd0;
        for (int k = 0; k < 600; k++)
            cycle(1'($urandom % 2), 8'($urandom), ($urandom % 4) == 0);
        drain();

        // Reset during the 4th bit's HIGH phase.
        a0 = cyc + 1;
        cycle(1'b1, 8'hC6, 1'b1);
        for (int k = 0; k < 40 && cyc < a0 + 17; k++) step();
        chk("pre_rst_sclk", 32'(spi_sclk), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_cs_n", 32'(spi_cs_n), 32'd1);
        chk("rst_mid_sclk", 32'(spi_sclk), 32'd0);
        chk("rst_mid_rxv", 32'(rx_valid), 32'd0);
        paint_idle(cyc);
        step(); step();
        reset = 1'b0;
        a0 = cyc + 1;
        cycle(1'b1, 8'h0F, 1'b1);
        wait_sig(0, 100, tv);
        chk("post_rst_lat", 32'(tv - a0), 32'd35);
        chk("post_rst_rx", 32'(rx), 32'h0F);
        drain();

        // HALF_DIV=1 instance: 0x01 puts MOSI high only for the final bit (plus hold).
        f_hi = 0; f_rise = 0;
        f_start = 1'b1; f_tx = 8'h01; f_last = 1'b1; a0 = cyc + 1;
        step();
        f_start = 1'b0; f_tx = 8'hEE;
        wait_sig(4, 60, tv);
        chk("fast_latency", 32'(tv - a0), 32'd19);
        chk("fast_rx", 32'(f_rx), 32'h01);
        chk("fast_bits", 32'(f_bits), 32'h01);
        chk("fast_rises", 32'(f_rise), 32'd8);
        wait_sig(5, 20, tcs);
        chk("fast_tx_hi", 32'(f_hi), 32'd4);
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master_byte.md
Name: spi_master_byte

Overview:
- System-clock-domain SPI initiator (mode 0: SCLK idles low, MSB first).
- Shifts one byte out on spi_tx and captures one byte from spi_rx per transaction.
- Chip select stays low across multi-byte transfers until a byte flagged last completes.
- Drives the PET board's SPI responder byte engines from a host-side or test controller.

Parameters:
- HALF_DIV, 2, clk cycles per SCLK half-period (>=1); SCLK frequency = clk/(2*HALF_DIV).
- CS_SETUP, 2, clk cycles from spi_cs_n falling to first SCLK rising-phase start (>=1).
- CS_HOLD, 2, clk cycles SCLK stays low after the last byte before spi_cs_n rises (>=1).
- CS_IDLE, 4, minimum clk cycles spi_cs_n stays high before the next transaction (>=1).
- BYTE_GAP, 4, minimum clk cycles between bytes with spi_cs_n held low (>=1); gives the responder time to service its byte.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a byte; accepted on a clk edge where start & ready.
- tx  in  8  byte to send; sampled at accept.
- last  in  1  sampled at accept; 1 = release CS after this byte.
- ready  out  1  high in IDLE (after CS_IDLE) and in GAP (after BYTE_GAP).
- busy  out  1  high whenever spi_cs_n is low or CS_IDLE is running.
- rx  out  8  received byte; valid while rx_valid is high, held until next accept.
- rx_valid  out  1  one-clk pulse per completed byte.
- spi_cs_n  out  1  chip select, active low.
- spi_sclk  out  1  serial clock.
- spi_tx  out  1  serial data out (MOSI).
- spi_rx  in  1  serial data in (MISO).

Behaviour:
- All outputs are registered.
- Reset values: spi_cs_n=1, spi_sclk=0, spi_tx=0, rx=0, rx_valid=0, busy=0, ready=1.
- Reset asserted mid-transfer forces these values immediately (async). The partial byte is discarded and no rx_valid is issued.
- States: IDLE, SETUP, LOW, HIGH, GAP, HOLD, CSIDLE.
- One down-counter (phase timer) times every state. One 3-bit bit counter, 7 down to 0.
- IDLE, on accept:
  - latch tx into the shift register and latch last;
  - next edge: spi_cs_n=0, spi_tx=tx[7];
  - enter SETUP for CS_SETUP cycles.
- SETUP -> LOW. Also GAP, on accept -> LOW, with spi_tx=tx[7] on the next edge.
- LOW (HALF_DIV cycles, sclk=0) -> HIGH.
  - Entering HIGH sets sclk=1 and samples spi_rx into rx_shift[0], shifting left.
  - spi_rx is sampled on the clk edge that raises sclk.
- HIGH (HALF_DIV cycles):
  - End of phase sets sclk=0.
  - bit counter != 0: decrement, shift tx left, spi_tx = next MSB, -> LOW.
  - bit counter == 0: load rx from rx_shift, rx_valid=1 for exactly one cycle; -> HOLD if last, else GAP.
- GAP:
  - spi_cs_n stays 0, sclk stays 0.
  - ready rises after BYTE_GAP cycles; waits indefinitely for start.
- HOLD (CS_HOLD cycles) -> CSIDLE with spi_cs_n=1. CSIDLE (CS_IDLE cycles) -> IDLE, ready=1.
- Exactly 8 rising and 8 falling SCLK edges per byte. SCLK is always low when spi_cs_n changes.
- Latency: for an accept in IDLE at edge 0, the edge setting rx_valid is edge 1 + CS_SETUP + 2*8*HALF_DIV.
- start while ready=0 is ignored, with no side effect. start held high continuously starts a new byte at each first-ready edge.
- tx and last are don't-care except at accept.
- spi_tx holds its last driven bit in GAP/HOLD. It is 0 in IDLE/CSIDLE.
- Counters saturate or reload only. No wrap-around reachable; parameters are checked >=1 by elaboration assertion.

Decomposition:
- Package spi_pkg:
  - state enum spi_master_state_t (7 states, 3-bit);
  - SPI_BITS=8 constant;
  - function for phase-timer width from max(HALF_DIV, CS_SETUP, CS_HOLD, CS_IDLE, BYTE_GAP).
- One sub-module: spi_phase_timer.
  - Loadable down-counter with a load value and a one-cycle expired flag.
  - Used for all timed states.
- Shift registers and the FSM live in spi_master_byte.

Test Plan:
- Defaults; spi_tx looped to spi_rx. start with tx=0xA5, last=1 -> rx=0xA5; rx_valid at edge 35; exactly 8 sclk rising edges; spi_cs_n returns high 2 cycles after rx_valid; ready after 4 more.
- Against the spi_byte responder model replying 0x5A then 0xC3:
  - send 0x3C (last=0), then 0x81 (last=1);
  - master rx = 0x5A then 0xC3; responder receives 0x3C, 0x81;
  - spi_cs_n low throughout; each gap >=4 cycles with sclk=0.
- spi_rx tied 1 -> rx=0xFF; spi_rx tied 0 -> rx=0x00. With HALF_DIV=1, tx=0x01 -> spi_tx high only during the final bit.
- start pulsed during LOW/HIGH of a byte -> ignored: no extra rx_valid, sclk edge count stays 8.
- Assert reset during the 4th bit's HIGH phase:
  - same cycle: spi_cs_n=1, spi_sclk=0, rx_valid=0;
  - after release, a new 0x0F transfer completes correctly with rx=0x0F in loopback.
